// File: rtl/colour_encode_if.sv
// Bus bundle between the RGB->YUV encoder and its controller/SRAM port.
// The master side is the encoder and drives the SRAM request signals.
interface colour_encode_if;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport master (
        input  start, sram_rdata,
        output busy, done, sram_addr, sram_we, sram_wdata
    );

    modport slave (
        output start, sram_rdata,
        input  busy, done, sram_addr, sram_we, sram_wdata
    );
endinterface

// File: rtl/colour_encode_datapath.sv
// RGB->YUV 4:2:2 encoder: reads 6 packed RGB words per 4-pixel group from a single
// SRAM port and writes two Y words, one U word and one V word (12 cycles per group).
module colour_encode_datapath #(
    parameter int unsigned NUM_PIXELS = 76800,
    parameter int unsigned Y_BASE     = 0,
    parameter int unsigned U_BASE     = 38400,
    parameter int unsigned V_BASE     = 57600,
    parameter int unsigned RGB_BASE   = 76800
) (
    input  logic              clk,
    input  logic              rst,
    colour_encode_if.master   bus
);
    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NUM_GROUPS = NUM_PIXELS / 4;
    localparam int unsigned GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_DRAIN, S_CALC, S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V, S_DONE
    } state_t;

    state_t             state, state_n;
    logic [2:0]         rd_idx, rd_idx_n;
    logic [GRP_W-1:0]   grp, grp_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic               we_q, we_n;
    logic [DATA_W-1:0]  wdata_q, wdata_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;

    logic [DATA_W-1:0]  words [6];
    logic [7:0]         r [4];
    logic [7:0]         g [4];
    logic [7:0]         b [4];
    logic [7:0]         y_c [4];
    logic [7:0]         u_c [2];
    logic [7:0]         v_c [2];
    logic [7:0]         y_q [4];
    logic [7:0]         u_q [2];
    logic [7:0]         v_q [2];

    function automatic logic [7:0] sat8(input logic signed [31:0] x);
        if (x < 32'sd0)        return 8'd0;
        else if (x > 32'sd255) return 8'd255;
        else                   return x[7:0];
    endfunction

    function automatic logic [7:0] calc_y(input logic [7:0] rr, input logic [7:0] gg,
                                          input logic [7:0] bb);
        logic signed [31:0] acc;
        acc = 32'sd16843 * $signed(32'(rr)) + 32'sd33030 * $signed(32'(gg))
            + 32'sd6423 * $signed(32'(bb)) + 32'sd32768;
        return sat8(32'sd16 + (acc >>> 16));
    endfunction

    function automatic logic [7:0] calc_u(input logic [8:0] rs, input logic [8:0] gs,
                                          input logic [8:0] bs);
        logic signed [31:0] acc;
        acc = 32'sd28770 * $signed(32'(bs)) - 32'sd9699 * $signed(32'(rs))
            - 32'sd19071 * $signed(32'(gs)) + 32'sd65536;
        return sat8(32'sd128 + (acc >>> 17));
    endfunction

    function automatic logic [7:0] calc_v(input logic [8:0] rs, input logic [8:0] gs,
                                          input logic [8:0] bs);
        logic signed [31:0] acc;
        acc = 32'sd28770 * $signed(32'(rs)) - 32'sd24117 * $signed(32'(gs))
            - 32'sd4653 * $signed(32'(bs)) + 32'sd65536;
        return sat8(32'sd128 + (acc >>> 17));
    endfunction

    function automatic logic [ADDR_W-1:0] rgb_addr(input logic [GRP_W-1:0] gi,
                                                   input logic [2:0] wi);
        return ADDR_W'(RGB_BASE + 32'd6 * 32'(gi) + 32'(wi));
    endfunction

    // Word layout per pair: {R0,G0},{B0,R1},{G1,B1}
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            r[2*k]   = words[3*k][15:8];
            g[2*k]   = words[3*k][7:0];
            b[2*k]   = words[3*k+1][15:8];
            r[2*k+1] = words[3*k+1][7:0];
            g[2*k+1] = words[3*k+2][15:8];
            b[2*k+1] = words[3*k+2][7:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) y_c[i] = calc_y(r[i], g[i], b[i]);
        for (int k = 0; k < 2; k++) begin
            u_c[k] = calc_u(9'(r[2*k]) + 9'(r[2*k+1]), 9'(g[2*k]) + 9'(g[2*k+1]),
                            9'(b[2*k]) + 9'(b[2*k+1]));
            v_c[k] = calc_v(9'(r[2*k]) + 9'(r[2*k+1]), 9'(g[2*k]) + 9'(g[2*k+1]),
                            9'(b[2*k]) + 9'(b[2*k+1]));
        end
    end

    // Next state and next (registered) outputs
    always_comb begin
        state_n  = state;
        rd_idx_n = rd_idx;
        grp_n    = grp;
        addr_n   = addr_q;
        we_n     = 1'b0;
        wdata_n  = wdata_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n  = S_RD;
                    rd_idx_n = 3'd0;
                    busy_n   = 1'b1;
                    addr_n   = rgb_addr(grp, 3'd0);
                end
            end
            S_RD: begin
                if (rd_idx == 3'd5) begin
                    state_n = S_DRAIN;
                end else begin
                    rd_idx_n = rd_idx + 3'd1;
                    addr_n   = rgb_addr(grp, rd_idx + 3'd1);
                end
            end
            S_DRAIN: state_n = S_CALC;
            S_CALC: begin
                state_n = S_WR_Y0;
                we_n    = 1'b1;
                addr_n  = ADDR_W'(Y_BASE + 32'd2 * 32'(grp));
                wdata_n = {y_c[0], y_c[1]};
            end
            S_WR_Y0: begin
                state_n = S_WR_Y1;
                we_n    = 1'b1;
                addr_n  = ADDR_W'(Y_BASE + 32'd2 * 32'(grp) + 32'd1);
                wdata_n = {y_q[2], y_q[3]};
            end
            S_WR_Y1: begin
                state_n = S_WR_U;
                we_n    = 1'b1;
                addr_n  = ADDR_W'(U_BASE + 32'(grp));
                wdata_n = {u_q[0], u_q[1]};
            end
            S_WR_U: begin
                state_n = S_WR_V;
                we_n    = 1'b1;
                addr_n  = ADDR_W'(V_BASE + 32'(grp));
                wdata_n = {v_q[0], v_q[1]};
            end
            S_WR_V: begin
                if (grp == GRP_W'(NUM_GROUPS - 1)) begin
                    state_n = S_DONE;
                    grp_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n  = S_RD;
                    grp_n    = grp + GRP_W'(1);
                    rd_idx_n = 3'd0;
                    addr_n   = rgb_addr(grp + GRP_W'(1), 3'd0);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            rd_idx  <= '0;
            grp     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            rd_idx  <= rd_idx_n;
            grp     <= grp_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Read word i arrives one cycle after its address: capture in RD i+1, word 5 in DRAIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) words[i] <= '0;
            for (int i = 0; i < 4; i++) y_q[i] <= '0;
            for (int k = 0; k < 2; k++) begin
                u_q[k] <= '0;
                v_q[k] <= '0;
            end
        end else begin
            if (state == S_RD && rd_idx != 3'd0) words[rd_idx - 3'd1] <= bus.sram_rdata;
            if (state == S_DRAIN)                words[5] <= bus.sram_rdata;
            if (state == S_CALC) begin
                for (int i = 0; i < 4; i++) y_q[i] <= y_c[i];
                for (int k = 0; k < 2; k++) begin
                    u_q[k] <= u_c[k];
                    v_q[k] <= v_c[k];
                end
            end
        end
    end

    assign bus.sram_addr  = addr_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_colour_encode_datapath.sv
// Scoreboard bench for colour_encode_datapath on a 16-pixel frame (4 groups) with
// hand-computed Y/U/V words for black, white, red, green/blue and mixed groups.
module tb_colour_encode_datapath;
    localparam int unsigned NPIX = 16;
    localparam int unsigned YB = 0, UB = 8, VB = 12, RB = 16;
    localparam int unsigned GROUPS = 4;
    localparam int unsigned FRAME_CYC = 12 * GROUPS;
    localparam int unsigned WR_PER_FRAME = 4 * GROUPS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    colour_encode_if bus();

    colour_encode_datapath #(
        .NUM_PIXELS(NPIX), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] mem [0:63];
    always @(posedge clk) bus.sram_rdata <= mem[bus.sram_addr[5:0]];

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] w [6];
        logic [15:0] y0, y1, u, v;
    } vec_t;

    vec_t vecs [5];
    wr_t  exp_q [$];
    int   checks = 0;
    int   passes = 0;
    int   done_count = 0;
    int   busy_cyc = 0;
    int   wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic set_vec(input int k, input logic [15:0] w0, w1, w2, w3, w4, w5,
                           input logic [15:0] y0, y1, u, v);
        vecs[k].w[0] = w0; vecs[k].w[1] = w1; vecs[k].w[2] = w2;
        vecs[k].w[3] = w3; vecs[k].w[4] = w4; vecs[k].w[5] = w5;
        vecs[k].y0 = y0; vecs[k].y1 = y1; vecs[k].u = u; vecs[k].v = v;
    endtask

    task automatic load_frame(input int a, b, c, d);
        int sel [4];
        sel = '{a, b, c, d};
        for (int gi = 0; gi < 4; gi++)
            for (int i = 0; i < 6; i++) mem[RB + 6*gi + i] = vecs[sel[gi]].w[i];
    endtask

    task automatic expect_frame(input int a, b, c, d);
        int  sel [4];
        wr_t it;
        sel = '{a, b, c, d};
        for (int gi = 0; gi < 4; gi++) begin
            it.addr = 18'(YB + 2*gi);     it.data = vecs[sel[gi]].y0; exp_q.push_back(it);
            it.addr = 18'(YB + 2*gi + 1); it.data = vecs[sel[gi]].y1; exp_q.push_back(it);
            it.addr = 18'(UB + gi);       it.data = vecs[sel[gi]].u;  exp_q.push_back(it);
            it.addr = 18'(VB + gi);       it.data = vecs[sel[gi]].v;  exp_q.push_back(it);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_count < target; i++) @(negedge clk);
        check("done_count", 32'(done_count), 32'(target));
    endtask

    // Monitor: pops the scoreboard on every write and checks per-frame timing at done
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                busy_cyc = 0;
                wr_cnt = 0;
            end else begin
                if (bus.busy) busy_cyc++;
                if (bus.sram_we) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                                 bus.sram_addr, bus.sram_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(bus.sram_addr), 32'(e.addr));
                        check("wr_data", 32'(bus.sram_wdata), 32'(e.data));
                    end
                end
                if (bus.done) begin
                    done_count++;
                    check("frame_cycles", 32'(busy_cyc), 32'(FRAME_CYC));
                    check("frame_writes", 32'(wr_cnt), 32'(WR_PER_FRAME));
                    check("busy_in_done", 32'(bus.busy), 32'd0);
                    busy_cyc = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_vec(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h1010, 16'h1010, 16'h8080, 16'h8080);
        set_vec(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
        set_vec(2, 16'hFF00, 16'h00FF, 16'h0000, 16'hFF00, 16'h00FF, 16'h0000,
                16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0);
        set_vec(3, 16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 16'hFF00, 16'h00FF,
                16'h9191, 16'h2929, 16'h36F0, 16'h226E);
        set_vec(4, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF,
                16'h5210, 16'h1029, 16'h6DB8, 16'hB877);
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

        rst = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(bus.busy),       32'd0);
        check("rst_done",  32'(bus.done),       32'd0);
        check("rst_we",    32'(bus.sram_we),    32'd0);
        check("rst_addr",  32'(bus.sram_addr),  32'd0);
        check("rst_wdata", 32'(bus.sram_wdata), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Frame A with a start pulse mid-frame that must be ignored
        load_frame(0, 1, 2, 3);
        expect_frame(0, 1, 2, 3);
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done(1, 200);

        // Frame B; start raised during the DONE cycle must be ignored
        repeat (3) @(negedge clk);
        load_frame(4, 3, 2, 1);
        expect_frame(4, 3, 2, 1);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        check("done_seen_b", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_done_start", 32'(bus.busy), 32'd0);
        check("done_count_b", 32'(done_count), 32'd2);

        // Reset during RD of group 3, then restart
        load_frame(0, 1, 2, 3);
        expect_frame(0, 1, 2, 3);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.sram_addr == 18'(RB + 6*3 + 1)) break;
        end
        check("reached_grp3_rd", 32'(bus.sram_addr), 32'(RB + 6*3 + 1));
        #1 rst = 1'b0;
        #1;
        check("abort_we",   32'(bus.sram_we),   32'd0);
        check("abort_busy", 32'(bus.busy),      32'd0);
        check("abort_addr", 32'(bus.sram_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_no_done", 32'(done_count), 32'd2);
        expect_frame(0, 1, 2, 3);
        pulse_start();
        wait_done(3, 200);

        // start held high: two frames back to back
        repeat (3) @(negedge clk);
        expect_frame(0, 1, 2, 3);
        expect_frame(0, 1, 2, 3);
        bus.start = 1'b1;
        wait_done(4, 200);
        for (int i = 0; i < 10 && !bus.busy; i++) @(negedge clk);
        check("b2b_restart_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(5, 200);
        repeat (20) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);
        check("final_done_count", 32'(done_count), 32'd5);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
